// File: rtl/dsp_ctrl_axil_slave.sv
// AXI4-Lite register bank for the DSP chain: control, pulse and config words out,
// live status and a version constant back to the PS.
module dsp_ctrl_axil_slave #(
    parameter int          C_S00_AXI_DATA_WIDTH = 32,
    parameter int          C_S00_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] VERSION              = 32'h0001_0000
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_areset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     ctrl_out,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     pulse_out,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     cfg0_out,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     cfg1_out,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     cfg2_out,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     cfg3_out,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     status_in
);

    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t         r_wstate, w_wstate_nxt;
    rstate_t         r_rstate, w_rstate_nxt;
    logic            r_live;
    logic            r_aw_done, r_w_done;
    logic [2:0]      r_awidx;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_wstrb;
    logic [1:0]      r_bresp;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   r_ctrl, r_pulse, r_cfg0, r_cfg1, r_cfg2, r_cfg3;

    logic            w_aw_hs, w_w_hs, w_ar_hs, w_apply;
    logic [2:0]      w_widx;
    logic [DW-1:0]   w_wdata;
    logic [SW-1:0]   w_wstrb;
    logic [DW-1:0]   w_rd_word;
    logic            w_unused;

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++)
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        return res;
    endfunction

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // r_live keeps the ready lines low while reset is held
    assign s00_axi_awready = r_live && (r_wstate == W_IDLE) && !r_aw_done;
    assign s00_axi_wready  = r_live && (r_wstate == W_IDLE) && !r_w_done;
    assign s00_axi_arready = r_live && (r_rstate == R_IDLE);
    assign s00_axi_bvalid  = (r_wstate == W_RESP);
    assign s00_axi_rvalid  = (r_rstate == R_DATA);
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rdata   = r_rdata;

    assign w_aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_w_hs  = s00_axi_wvalid && s00_axi_wready;
    assign w_ar_hs = s00_axi_arvalid && s00_axi_arready;

    // A beat arriving this cycle completes the pair just as well as a captured one
    assign w_widx  = r_aw_done ? r_awidx : s00_axi_awaddr[4:2];
    assign w_wdata = r_w_done ? r_wdata : s00_axi_wdata;
    assign w_wstrb = r_w_done ? r_wstrb : s00_axi_wstrb;
    assign w_apply = (r_wstate == W_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    assign ctrl_out  = r_ctrl;
    assign pulse_out = r_pulse;
    assign cfg0_out  = r_cfg0;
    assign cfg1_out  = r_cfg1;
    assign cfg2_out  = r_cfg2;
    assign cfg3_out  = r_cfg3;

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_live   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_live   <= 1'b1;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_rstate_nxt = r_rstate;
        case (r_wstate)
            W_IDLE:  if (w_apply) w_wstate_nxt = W_RESP;
            W_RESP:  if (s00_axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (s00_axi_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= 2'b00;
            r_ctrl    <= '0;
            r_pulse   <= '0;
            r_cfg0    <= '0;
            r_cfg1    <= '0;
            r_cfg2    <= '0;
            r_cfg3    <= '0;
        end else begin
            r_pulse <= '0;
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
                r_awidx   <= s00_axi_awaddr[4:2];
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
                r_wdata  <= s00_axi_wdata;
                r_wstrb  <= s00_axi_wstrb;
            end
            if (w_apply) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_bresp   <= (w_widx[2:1] == 2'b11) ? 2'b10 : 2'b00;
                case (w_widx)
                    3'd0:    r_ctrl  <= f_merge(r_ctrl, w_wdata, w_wstrb);
                    3'd1:    r_pulse <= f_merge('0, w_wdata, w_wstrb);
                    3'd2:    r_cfg0  <= f_merge(r_cfg0, w_wdata, w_wstrb);
                    3'd3:    r_cfg1  <= f_merge(r_cfg1, w_wdata, w_wstrb);
                    3'd4:    r_cfg2  <= f_merge(r_cfg2, w_wdata, w_wstrb);
                    3'd5:    r_cfg3  <= f_merge(r_cfg3, w_wdata, w_wstrb);
                    default: ;
                endcase
            end
        end
    end

    // Read data comes from register state before this edge's write lands
    always_comb begin
        w_rd_word = '0;
        case (s00_axi_araddr[4:2])
            3'd0:    w_rd_word = r_ctrl;
            3'd2:    w_rd_word = r_cfg0;
            3'd3:    w_rd_word = r_cfg1;
            3'd4:    w_rd_word = r_cfg2;
            3'd5:    w_rd_word = r_cfg3;
            3'd6:    w_rd_word = status_in;
            3'd7:    w_rd_word = VERSION;
            default: w_rd_word = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset)
            r_rdata <= '0;
        else if (w_ar_hs)
            r_rdata <= w_rd_word;
    end

endmodule

// File: tb/tb_dsp_ctrl_axil_slave.sv
// Bench for dsp_ctrl_axil_slave: vector table of single-beat accesses plus
// hand-written latency, backpressure, pulse, collision and reset-abort sequences.
module tb_dsp_ctrl_axil_slave;

    localparam int CYC_LIMIT = 50;

    logic        clk;
    logic        rst;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, status_in;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] ctrl_out, pulse_out, cfg0_out, cfg1_out, cfg2_out, cfg3_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] b_q[$];
    logic [31:0] r_q[$];

    dsp_ctrl_axil_slave dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (3'b000),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (3'b000),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .ctrl_out       (ctrl_out),
        .pulse_out      (pulse_out),
        .cfg0_out       (cfg0_out),
        .cfg1_out       (cfg1_out),
        .cfg2_out       (cfg2_out),
        .cfg3_out       (cfg3_out),
        .status_in      (status_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Scoreboard: every B/R handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (b_q.size() == 0) fail_msg("unexpected_b");
                else chk("bresp", {30'd0, bresp}, b_q.pop_front());
            end
            if (rvalid && rready) begin
                if (r_q.size() == 0) fail_msg("unexpected_r");
                else begin
                    chk("rdata", rdata, r_q.pop_front());
                    chk("rresp", {30'd0, rresp}, 32'd0);
                end
            end
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] eb);
        bit aw_ok, w_ok, aw_hs, w_hs, b_ok;
        aw_ok = 0; w_ok = 0; b_ok = 0;
        b_q.push_back({30'd0, eb});
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        for (int c = 0; c < CYC_LIMIT && !(aw_ok && w_ok); c++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 0; aw_ok = 1; end
            if (w_hs)  begin wvalid = 0;  w_ok = 1;  end
        end
        if (!(aw_ok && w_ok)) begin
            fail_msg("wr_aw_w_timeout");
            awvalid = 0; wvalid = 0;
        end
        for (int c = 0; c < CYC_LIMIT && !b_ok; c++) begin
            @(negedge clk);
            b_ok = bvalid && bready;
            @(posedge clk); #1;
        end
        if (!b_ok) fail_msg("wr_b_timeout");
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] ed);
        bit ar_ok, ar_hs, r_ok;
        ar_ok = 0; r_ok = 0;
        r_q.push_back(ed);
        araddr = a; arvalid = 1; rready = 1;
        for (int c = 0; c < CYC_LIMIT && !ar_ok; c++) begin
            @(negedge clk);
            ar_hs = arvalid && arready;
            @(posedge clk); #1;
            if (ar_hs) begin arvalid = 0; ar_ok = 1; end
        end
        if (!ar_ok) begin fail_msg("rd_ar_timeout"); arvalid = 0; end
        for (int c = 0; c < CYC_LIMIT && !r_ok; c++) begin
            @(negedge clk);
            r_ok = rvalid && rready;
            @(posedge clk); #1;
        end
        if (!r_ok) fail_msg("rd_r_timeout");
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit wr, input logic [4:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.exp = e;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk(1, 5'h00, 32'h1122_3344, 4'hF, 32'd0));
        vecs.push_back(mk(0, 5'h00, 32'h0,         4'h0, 32'h1122_3344));
        for (int w = 2; w <= 5; w++)
            vecs.push_back(mk(1, 5'(w * 4), 32'hAABB_CCDD, 4'hF, 32'd0));
        for (int w = 2; w <= 5; w++)
            vecs.push_back(mk(1, 5'(w * 4), 32'(w - 1), 4'b0101, 32'd0));
        for (int w = 2; w <= 5; w++)
            vecs.push_back(mk(0, 5'(w * 4), 32'h0, 4'h0, 32'hAA00_CC00 | 32'(w - 1)));
        vecs.push_back(mk(0, 5'h04, 32'h0,         4'h0, 32'h0));
        vecs.push_back(mk(1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'd2));
        vecs.push_back(mk(0, 5'h1C, 32'h0,         4'h0, 32'h0001_0000));
        vecs.push_back(mk(1, 5'h18, 32'h1234_5678, 4'hF, 32'd2));
        vecs.push_back(mk(0, 5'h18, 32'h0,         4'h0, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 5'h03, 32'h0,         4'h0, 32'h1122_3344));
        vecs.push_back(mk(1, 5'h01, 32'h0000_00AB, 4'b0001, 32'd0));
        vecs.push_back(mk(0, 5'h00, 32'h0,         4'h0, 32'h1122_33AB));

        rst = 1; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; arvalid = 0;
        wdata = 0; wstrb = 0; bready = 1; rready = 1; status_in = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        chk("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        chk("rst_resp_data", {28'd0, bresp, rresp} | rdata, 32'd0);
        chk("rst_regs", ctrl_out | pulse_out | cfg0_out | cfg1_out | cfg2_out | cfg3_out, 32'd0);
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_ready", {29'd0, awready, wready, arready}, 32'h7);

        foreach (vecs[i]) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp[1:0]);
            else            axi_read(vecs[i].addr, vecs[i].exp);
        end
        chk("cfg0_out", cfg0_out, 32'hAA00_CC01);
        chk("cfg1_out", cfg1_out, 32'hAA00_CC02);
        chk("cfg2_out", cfg2_out, 32'hAA00_CC03);
        chk("cfg3_out", cfg3_out, 32'hAA00_CC04);

        // Simultaneous AW/W: update and bvalid one cycle after the handshake
        b_q.push_back(32'd0);
        awaddr = 5'h00; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        @(negedge clk);
        chk("lat_readies", {30'd0, awready, wready}, 32'h3);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        chk("lat_bvalid", {31'd0, bvalid}, 32'd1);
        chk("lat_ctrl", ctrl_out, 32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("lat_after_b", {30'd0, bvalid, awready}, 32'h1);

        // Pulse word: one cycle of pulse_out, then zero
        b_q.push_back(32'd0);
        awaddr = 5'h04; wdata = 32'h0000_0081; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        chk("pulse_on", pulse_out, 32'h0000_0081);
        @(posedge clk); #1;
        chk("pulse_off", pulse_out, 32'h0);
        axi_read(5'h04, 32'h0);

        // W three cycles ahead of AW, then five cycles of B backpressure
        b_q.push_back(32'd0);
        bready = 0;
        awaddr = 5'h0C; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        chk("stag_wready", {31'd0, wready}, 32'd1);
        @(posedge clk); #1;
        wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("stag_wait_state", {30'd0, wready, bvalid}, 32'd0);
            chk("stag_wait_cfg1", cfg1_out, 32'hAA00_CC02);
            if (i == 2) awvalid = 1;
            if (i < 2) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        chk("stag_awready", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 0;
        chk("stag_cfg1", cfg1_out, 32'h5A5A_5A5A);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {28'd0, bvalid, awready, wready, 1'b0}, 32'h8);
            chk("bp_bresp", {30'd0, bresp}, 32'd0);
            @(posedge clk); #1;
        end
        bready = 1;
        @(posedge clk); #1;
        chk("bp_release", {29'd0, bvalid, awready, wready}, 32'h3);

        // Read and write of the same word in one cycle: read sees the old value
        b_q.push_back(32'd0);
        r_q.push_back(32'hAA00_CC01);
        awaddr = 5'h08; wdata = 32'h1357_9BDF; wstrb = 4'hF; araddr = 5'h08;
        awvalid = 1; wvalid = 1; arvalid = 1; rready = 1; bready = 1;
        @(negedge clk);
        chk("coll_readies", {29'd0, awready, wready, arready}, 32'h7);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("coll_valids", {30'd0, bvalid, rvalid}, 32'h3);
        @(posedge clk); #1;
        axi_read(5'h08, 32'h1357_9BDF);

        // Reset one cycle after AW, before W: transaction dropped, outputs cleared
        awaddr = 5'h00; wdata = 32'h0; awvalid = 1;
        @(negedge clk);
        chk("abort_awready", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("abort_regs", ctrl_out | pulse_out | cfg0_out | cfg1_out | cfg2_out | cfg3_out, 32'd0);
        chk("abort_ctrl", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
        chk("abort_data", {30'd0, bresp} | rdata, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        chk("abort_ready", {28'd0, awready, wready, arready, bvalid}, 32'hE);
        axi_write(5'h00, 32'h0BAD_CAFE, 4'hF, 2'b00);
        axi_read(5'h00, 32'h0BAD_CAFE);

        repeat (2) @(posedge clk);
        #1;
        chk("b_q_drained", b_q.size(), 32'd0);
        chk("r_q_drained", r_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
